// File: rtl/my_cpu_pkg.sv
// ============================================================================
// Module   : my_cpu_pkg
// Brief    : Shared state encoding and instruction bit positions for the
//            Hack-style control/register stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package my_cpu_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    WRITE_M = 2'd2
  } cpu_state_t;

  localparam int CI_BIT     = 15;
  localparam int AM_BIT     = 12;
  localparam int ALU_CTL_HI = 11;
  localparam int ALU_CTL_LO = 6;
  localparam int DEST_A     = 5;
  localparam int DEST_D     = 4;
  localparam int DEST_M     = 3;
  localparam int J_LT       = 2;
  localparam int J_EQ       = 1;
  localparam int J_GT       = 0;

endpackage

`default_nettype wire

// File: rtl/my_jump_cond.sv
// ============================================================================
// Module   : my_jump_cond
// Brief    : Combinational jump decision from the jump field and ALU flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_jump_cond
  import my_cpu_pkg::*;
(
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  output logic       jmp
);

  assign jmp = (jbits[J_LT] & ng) | (jbits[J_EQ] & zr) | (jbits[J_GT] & ~ng & ~zr);

endmodule

`default_nettype wire

// File: rtl/my_cpu_state.sv
// ============================================================================
// Module   : my_cpu_state
// Brief    : A/D/PC/IR register stage with handshaked fetch and memory write,
//            driving the external ALU and committing its result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module my_cpu_state
  import my_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] m_addr,
  input  logic [15:0] m_rdata,
  output logic [15:0] m_wdata,
  output logic        m_we,
  input  logic        m_ack,
  output logic        retire
);

  cpu_state_t  r_state;
  cpu_state_t  w_state_nxt;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_res_q;
  logic        r_jmp_q;

  logic        w_jmp;
  logic        w_is_c;
  logic        w_needs_m;
  logic [15:0] w_commit_res;
  logic        w_commit_jmp;
  logic [15:0] w_pc_inc;

  assign w_is_c    = r_ir[CI_BIT];
  assign w_needs_m = r_ir[CI_BIT] & r_ir[DEST_M];
  assign w_pc_inc  = r_pc + 16'd1;

  my_jump_cond u_jump_cond (
    .jbits (r_ir[J_LT:J_GT]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .jmp   (w_jmp)
  );

  // A memory-writing instruction commits from the values captured in EXEC.
  assign w_commit_res = (r_state == WRITE_M) ? r_res_q : alu_out;
  assign w_commit_jmp = (r_state == WRITE_M) ? r_jmp_q : w_jmp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:   if (instr_valid) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = w_needs_m ? WRITE_M : FETCH;
      WRITE_M: if (m_ack) w_state_nxt = FETCH;
      default: w_state_nxt = FETCH;
    endcase
  end

  always_comb begin
    instr_ready = 1'b0;
    m_we        = 1'b0;
    retire      = 1'b0;
    case (r_state)
      FETCH:   instr_ready = ~rst;
      EXEC:    retire      = ~w_needs_m;
      WRITE_M: begin
        m_we   = 1'b1;
        retire = m_ack;
      end
      default: begin
        instr_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= 16'd0;
      r_d     <= 16'd0;
      r_pc    <= 16'd0;
      r_ir    <= 16'd0;
      r_res_q <= 16'd0;
      r_jmp_q <= 1'b0;
    end else begin
      if (instr_ready && instr_valid) begin
        r_ir <= instr;
      end
      if ((r_state == EXEC) && w_is_c) begin
        r_res_q <= alu_out;
        r_jmp_q <= w_jmp;
      end
      if (retire) begin
        if (!w_is_c) begin
          r_a  <= {1'b0, r_ir[14:0]};
          r_pc <= w_pc_inc;
        end else begin
          if (r_ir[DEST_A]) r_a <= w_commit_res;
          if (r_ir[DEST_D]) r_d <= w_commit_res;
          // Jump target is A as it stood before this instruction.
          r_pc <= w_commit_jmp ? r_a : w_pc_inc;
        end
      end
    end
  end

  assign pc      = r_pc;
  assign ir      = r_ir;
  assign alu_x   = r_d;
  assign alu_y   = r_ir[AM_BIT] ? m_rdata : r_a;
  assign m_addr  = r_a[14:0];
  assign m_wdata = r_res_q;

endmodule

`default_nettype wire

// File: tb/tb_my_cpu_state.sv
// ============================================================================
// Module   : tb_my_cpu_state
// Brief    : Scoreboard bench for my_cpu_state with an external ALU and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_my_cpu_state;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] m_addr;
  logic [15:0] m_rdata;
  logic [15:0] m_wdata;
  logic        m_we;
  logic        m_ack;
  logic        retire;

  always #5 clk = ~clk;

  my_cpu_state dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc          (pc),
    .ir          (ir),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .m_addr      (m_addr),
    .m_rdata     (m_rdata),
    .m_wdata     (m_wdata),
    .m_we        (m_we),
    .m_ack       (m_ack),
    .retire      (retire)
  );

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] d;
    logic [14:0] a_lo;
    int          cyc;
  } ret_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  ret_t        ret_q[$];
  wr_t         wr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [15:0] dut_mem[32768];
  logic [15:0] ref_mem[32768];
  logic [15:0] ma, md, mpc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 40503 + 17);
  endfunction

  // Hack ALU: zx nx zy ny f no
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, ir[11:6]);
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];
  assign m_rdata = dut_mem[m_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: architectural effect of one instruction, plus when it should retire.
  function automatic void ref_exec(input logic [15:0] ins, input int issue_cyc, input int ack_dly);
    ret_t        r;
    wr_t         w;
    logic [15:0] y, res, npc;
    logic        take;
    r.ir  = ins;
    r.cyc = issue_cyc + 1;
    if (!ins[15]) begin
      ma  = {1'b0, ins[14:0]};
      mpc = mpc + 16'd1;
    end else begin
      y    = ins[12] ? ref_mem[ma[14:0]] : ma;
      res  = hack_alu(md, y, ins[11:6]);
      take = (ins[2] && ($signed(res) < 0)) || (ins[1] && (res == 16'h0000)) ||
             (ins[0] && ($signed(res) > 0));
      npc  = take ? ma : mpc + 16'd1;
      if (ins[3]) begin
        w.addr = ma[14:0];
        w.data = res;
        wr_q.push_back(w);
        ref_mem[ma[14:0]] = res;
        r.cyc = issue_cyc + 2 + ack_dly;
      end
      if (ins[5]) ma = res;
      if (ins[4]) md = res;
      mpc = npc;
    end
    r.pc   = mpc;
    r.d    = md;
    r.a_lo = ma[14:0];
    ret_q.push_back(r);
  endfunction

  task automatic do_instr(input logic [15:0] ins, input int ack_dly);
    int guard  = 0;
    int waited = 0;
    while (!instr_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    instr       = ins;
    instr_valid = 1'b1;
    m_ack       = 1'($urandom_range(0, 1));
    ref_exec(ins, cyc, ack_dly);
    @(posedge clk); #1;
    guard = 0;
    while (!instr_ready) begin
      instr       = 16'($urandom);
      instr_valid = 1'($urandom_range(0, 1));
      if (m_we) begin
        m_ack = (waited >= ack_dly);
        waited++;
      end else begin
        m_ack = 1'($urandom_range(0, 1));
      end
      guard++;
      if (guard > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL exec_timeout: instr %h never returned to fetch", ins);
        break;
      end
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    m_ack       = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 9) < 4) begin
      w[15] = 1'b0;
      if ($urandom_range(0, 1) == 1) w[14:0] = 15'($urandom_range(0, 15));
    end else begin
      w[15] = 1'b1;
    end
    return w;
  endfunction

  // Memory model seen by the DUT: writes are taken on the acknowledged edge.
  initial begin
    logic        do_wr;
    logic [14:0] wa;
    logic [15:0] wd;
    for (int i = 0; i < 32768; i++) dut_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      do_wr = m_we && m_ack && !rst;
      wa    = m_addr;
      wd    = m_wdata;
      @(posedge clk);
      if (do_wr) dut_mem[wa] = wd;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT writes or retires.
  initial begin
    ret_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_we) begin
          if (wr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %h data %h", m_addr, m_wdata);
          end else begin
            chk("m_addr", 32'(m_addr), 32'(wr_q[0].addr));
            chk("m_wdata", 32'(m_wdata), 32'(wr_q[0].data));
            if (m_ack) void'(wr_q.pop_front());
          end
        end
        if (retire) begin
          if (ret_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_retire: ir %h pc %h", ir, pc);
          end else begin
            r = ret_q.pop_front();
            chk("retire_cycle", 32'(cyc), 32'(r.cyc));
            chk("retire_ir", 32'(ir), 32'(r.ir));
            @(posedge clk); #1;
            chk("pc", 32'(pc), 32'(r.pc));
            chk("d_reg", 32'(alu_x), 32'(r.d));
            chk("a_lo", 32'(m_addr), 32'(r.a_lo));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] save_a;
    logic [15:0] save_v;
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
    ma  = 16'd0;
    md  = 16'd0;
    mpc = 16'd0;

    rst         = 1'b1;
    instr       = 16'h1234;
    instr_valid = 1'b1;
    m_ack       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_d", 32'(alu_x), 32'd0);
    chk("rst_a", 32'(m_addr), 32'd0);
    rst         = 1'b0;
    instr_valid = 1'b0;
    m_ack       = 1'b0;
    #1;
    chk("ready_after_release", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;

    do_instr(16'h1234, 0);
    do_instr(16'h0005, 0);
    do_instr(16'hEC10, 0);
    do_instr(16'h0014, 0);
    do_instr(16'hE301, 0);
    do_instr(16'h0000, 0);
    do_instr(16'hEC10, 0);
    do_instr(16'h0014, 0);
    do_instr(16'hE301, 0);
    do_instr(16'h0007, 0);
    do_instr(16'hEC10, 0);
    do_instr(16'h0064, 0);
    do_instr(16'hE308, 1);
    do_instr(16'hFDE8, 3);
    do_instr(16'h000F, 0);
    do_instr(16'hEA87, 0);
    do_instr(16'h0000, 0);
    do_instr(16'hEA87, 0);
    do_instr(16'hEEA0, 0);
    do_instr(16'hEA87, 0);
    do_instr(16'h0042, 0);

    // Reset while a write is pending: the write must vanish with no commit.
    save_a      = ma[14:0];
    save_v      = ref_mem[save_a];
    instr       = 16'hFDE8;
    instr_valid = 1'b1;
    ref_exec(16'hFDE8, cyc, 0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("m_we_in_write", 32'(m_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("m_we_drop_on_rst", 32'(m_we), 32'd0);
    chk("retire_on_rst", 32'(retire), 32'd0);
    ret_q.delete();
    wr_q.delete();
    ref_mem[save_a] = save_v;
    ma  = 16'd0;
    md  = 16'd0;
    mpc = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("pc_after_rst", 32'(pc), 32'd0);
    chk("d_after_rst", 32'(alu_x), 32'd0);
    chk("a_after_rst", 32'(m_addr), 32'd0);
    chk("fetch_after_rst", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;

    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 2)) begin
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        m_ack       = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      m_ack = 1'b0;
      do_instr(rand_instr(), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("retire_queue_drained", 32'(ret_q.size()), 32'd0);
    chk("write_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
